note_sequencer: RTL and testbench

- Controller that sequences the square-wave oscillator through a programmable list of notes.
- Holds a small note table: per entry, a 12-bit half-period (drives the oscillator's count_max) and an 8-bit duration in ticks.
- On start, plays entries 0..seq_len-1 in order, once or looping.
- Drives count_max and the oscillator's active-low reset so each note starts phase-aligned and rests are silent.

---
 rtl/note_seq_pkg.sv | 21 ++
 rtl/note_table.sv | 22 ++
 rtl/note_sequencer.sv | 134 +++++++++++++
 tb/tb_note_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer and its note table.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  localparam int PERIOD_W = 12;
  localparam int DUR_W    = 8;
  localparam int ENTRY_W  = PERIOD_W + DUR_W;

  localparam logic [PERIOD_W-1:0] PERIOD_REST = '0;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUR_W-1:0]    dur;
  } note_t;

endpackage

// File: rtl/note_table.sv
// Small DEPTH x W storage: synchronous write, registered read, no reset on contents.
module note_table #(
  parameter int DEPTH = 16,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Read returns the pre-write contents when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps the square-wave oscillator through the note table, once or looping,
// holding the oscillator in reset during rests and between notes.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 12000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [PERIOD_W-1:0]        wr_period,
  input  logic [DUR_W-1:0]           wr_dur,
  input  logic [$clog2(DEPTH):0]     seq_len,
  input  logic                       loop,
  input  logic                       start,
  input  logic                       stop,
  output logic [PERIOD_W-1:0]        count_max,
  output logic                       osc_rstn,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   note_idx,
  output logic                       done,
  output state_e                     dbg_state
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               loop_q, loop_d;
  logic               done_d;
  logic [TICK_W-1:0]  tick_q;
  logic [8:0]         dur_q;
  logic               tick_wrap;
  logic               note_end;
  note_t              rd_note;

  // Address the table with next-cycle idx so the entry is ready during LOAD.
  note_table #(.DEPTH(DEPTH), .W(ENTRY_W)) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_period, wr_dur}),
    .rd_addr (idx_d),
    .rd_data (rd_note)
  );

  assign tick_wrap = (tick_q == TICK_LAST);
  assign note_end  = tick_wrap && (dur_q == 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start is a level request seen only in IDLE; stop overrides everything,
  // including start and a coinciding note end.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (seq_len != '0)) begin
            state_d = LOAD;
            idx_d   = '0;
            loop_d  = loop;
            if (seq_len > LEN_W'(DEPTH)) last_d = IDX_W'(DEPTH - 1);
            else                         last_d = IDX_W'(seq_len - 1'b1);
          end
        end
        LOAD: state_d = PLAY;
        PLAY: begin
          if (note_end) begin
            if (idx_q == last_q) begin
              if (loop_q) begin
                idx_d   = '0;
                state_d = LOAD;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      done      <= 1'b0;
      count_max <= '0;
      dur_q     <= '0;
      tick_q    <= '0;
    end else begin
      idx_q  <= idx_d;
      last_q <= last_d;
      loop_q <= loop_d;
      done   <= done_d;
      if (state_q == LOAD && !stop) begin
        count_max <= rd_note.period;
        dur_q     <= (rd_note.dur == '0) ? 9'd1 : {1'b0, rd_note.dur};
        tick_q    <= '0;
      end else if (state_q == PLAY) begin
        tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) dur_q <= dur_q - 9'd1;
      end
    end
  end

  assign osc_rstn  = (state_q == PLAY) && (count_max != PERIOD_REST);
  assign busy      = (state_q != IDLE);
  assign note_idx  = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: per-note and done events are checked
// against hand-computed records queued before each sequence starts.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int W        = 40;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [PERIOD_W-1:0] wr_period;
  logic [DUR_W-1:0]    wr_dur;
  logic [IDX_W:0]      seq_len;
  logic                loop;
  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] count_max;
  logic                osc_rstn;
  logic                busy;
  logic [IDX_W-1:0]    note_idx;
  logic                done;
  state_e              dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_dur(wr_dur), .seq_len(seq_len), .loop(loop),
    .start(start), .stop(stop), .count_max(count_max), .osc_rstn(osc_rstn),
    .busy(busy), .note_idx(note_idx), .done(done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Record: kind(2) idx(8) count_max(12) {rstn_any,rstn_all}(2) load_cycles(3) len(13)
  function automatic logic [W-1:0] mk_note(input int idx, input int cm,
                                           input logic [1:0] rs, input int ld,
                                           input int len);
    return {2'd1, 8'(idx), 12'(cm), rs, 3'(ld), 13'(len)};
  endfunction

  function automatic logic [W-1:0] mk_done(input logic b);
    return {2'd2, 37'd0, b};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int period, input int dur);
    wr_en     = 1'b1;
    wr_addr   = IDX_W'(addr);
    wr_period = PERIOD_W'(period);
    wr_dur    = DUR_W'(dur);
    tick(1);
    wr_en     = 1'b0;
  endtask

  task automatic start_seq(input int len, input logic lp);
    seq_len = (IDX_W+1)'(len);
    loop    = lp;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_idle_busy", {39'd0, busy}, 40'd0);
  endtask

  // monitor: collapses each PLAY stretch into one record and pops the scoreboard
  int          load_cnt = 0;
  bit          in_play  = 0;
  logic [7:0]  seg_idx;
  logic [11:0] seg_cm;
  logic        seg_any, seg_all;
  int          seg_ld, seg_len;

  task automatic pop_compare(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: got unexpected event %h required none", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (dbg_state == PLAY) begin
      if (!in_play) begin
        in_play  = 1;
        seg_idx  = 8'(note_idx);
        seg_cm   = count_max;
        seg_any  = osc_rstn;
        seg_all  = osc_rstn;
        seg_ld   = load_cnt;
        seg_len  = 0;
        load_cnt = 0;
      end
      seg_any = seg_any | osc_rstn;
      seg_all = seg_all & osc_rstn;
      seg_len++;
    end else if (in_play) begin
      in_play = 0;
      pop_compare("note_event", mk_note(seg_idx, seg_cm, {seg_any, seg_all},
                                        seg_ld, seg_len));
    end
    if (dbg_state == LOAD) load_cnt++;
    else if (dbg_state == IDLE) load_cnt = 0;
    if (done === 1'b1) pop_compare("done_event", mk_done(busy));
  end

  // main stimulus
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
    seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(3);
    check("reset_outputs", 40'({count_max, osc_rstn, busy, note_idx, done}), 40'd0);
    rst = 1'b0;
    tick(2);

    // one-shot: tone then rest
    write_entry(0, 5, 2);
    write_entry(1, 0, 1);
    exp_q.push_back(mk_note(0, 5, 2'b11, 1, 8));
    exp_q.push_back(mk_note(1, 0, 2'b00, 1, 4));
    exp_q.push_back(mk_done(1'b0));
    start_seq(2, 1'b0);
    check("load_cycle_busy_rstn", 40'({busy, osc_rstn}), 40'b10);
    tick(1);
    check("first_play_rstn_cm", 40'({osc_rstn, count_max}), 40'({1'b1, 12'd5}));
    wait_idle(100);
    tick(2);

    // looping, latched inputs changed while busy, stop mid-PLAY of entry1
    exp_q.push_back(mk_note(0, 5, 2'b11, 1, 8));
    exp_q.push_back(mk_note(1, 0, 2'b00, 1, 4));
    exp_q.push_back(mk_note(0, 5, 2'b11, 1, 8));
    exp_q.push_back(mk_note(1, 0, 2'b00, 1, 2));
    start_seq(2, 1'b1);
    seq_len = '0;
    loop    = 1'b0;
    tick(25);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("after_stop", 40'({busy, osc_rstn, note_idx}), 40'({1'b0, 1'b0, 2'd1}));
    tick(3);

    // zero duration acts as one tick; start pulse during PLAY ignored
    write_entry(0, 7, 0);
    exp_q.push_back(mk_note(0, 7, 2'b11, 1, 4));
    exp_q.push_back(mk_done(1'b0));
    start_seq(1, 1'b0);
    tick(2);
    seq_len = 3'd1;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    wait_idle(100);
    tick(2);

    // seq_len = 0 never starts
    start_seq(0, 1'b0);
    check("len0_busy_now", {39'd0, busy}, 40'd0);
    tick(3);
    check("len0_busy_later", {39'd0, busy}, 40'd0);

    // seq_len = DEPTH+1 plays DEPTH entries
    write_entry(0, 3, 1);
    write_entry(1, 0, 1);
    write_entry(2, 2, 1);
    write_entry(3, 1, 1);
    exp_q.push_back(mk_note(0, 3, 2'b11, 1, 4));
    exp_q.push_back(mk_note(1, 0, 2'b00, 1, 4));
    exp_q.push_back(mk_note(2, 2, 2'b11, 1, 4));
    exp_q.push_back(mk_note(3, 1, 2'b11, 1, 4));
    exp_q.push_back(mk_done(1'b0));
    start_seq(DEPTH + 1, 1'b0);
    wait_idle(200);
    tick(2);

    // start and stop together in IDLE
    seq_len = 3'd2;
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_same_cycle", {39'd0, busy}, 40'd0);
    tick(2);
    check("start_stop_still_idle", {39'd0, busy}, 40'd0);

    // rewrite playing entry, then async reset mid-PLAY
    write_entry(0, 5, 2);
    write_entry(1, 0, 1);
    exp_q.push_back(mk_note(0, 5, 2'b11, 1, 8));
    exp_q.push_back(mk_note(1, 0, 2'b00, 1, 4));
    exp_q.push_back(mk_note(0, 9, 2'b11, 1, 3));
    start_seq(2, 1'b1);
    tick(3);
    write_entry(0, 9, 2);
    check("rewrite_keeps_cm", 40'(count_max), 40'd5);
    tick(14);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 40'({count_max, osc_rstn, busy, note_idx, done}), 40'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    check("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
